// File: rtl/vsi_pwm_scheduler.sv
// Three-phase duty scheduler: shadows handshaked duty commands and releases them to the
// PWM legs on carrier-period ticks, with soft start, disable-at-tick and immediate fault trip.
module vsi_pwm_scheduler #(
  parameter int DW        = 10,
  parameter int DUTY_MAX  = 1000,
  parameter int RAMP_STEP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          fault,
  input  logic          period_tick,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] duty_a,
  input  logic [DW-1:0] duty_b,
  input  logic [DW-1:0] duty_c,
  output logic [DW-1:0] d_a,
  output logic [DW-1:0] d_b,
  output logic [DW-1:0] d_c,
  output logic          gate_en,
  output logic [1:0]    state,
  output logic          fault_latched
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [DW:0] DMAX = (DW+1)'(DUTY_MAX);
  localparam logic [DW:0] STEP = (DW+1)'(RAMP_STEP);

  state_t               state_q, state_d;
  logic [2:0][DW-1:0]   d_q, d_d;
  logic [2:0][DW-1:0]   sh_q, sh_d;
  logic [2:0][DW-1:0]   tgt_q, tgt_d;
  logic                 pending_q, pending_d;
  logic                 gate_en_q, gate_en_d;
  logic                 fault_latched_q, fault_latched_d;

  logic [2:0][DW-1:0]   duty_in, nt, ramped;
  logic                 xfer, ramp_done, trip;

  function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] v);
    logic [DW:0] w;
    w = {1'b0, v};
    return (w > DMAX) ? DMAX[DW-1:0] : v;
  endfunction

  // One soft-start step toward the target; DW+1 bits keep the difference from wrapping.
  function automatic logic [DW-1:0] ramp_step(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
    logic [DW:0] c, t, diff, r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t >= c) begin
      diff = t - c;
      if (diff > STEP) diff = STEP;
      r = c + diff;
    end else begin
      diff = c - t;
      if (diff > STEP) diff = STEP;
      r = c - diff;
    end
    return r[DW-1:0];
  endfunction

  assign duty_in   = {duty_c, duty_b, duty_a};
  assign cmd_ready = !rst && (state_q != S_FAULT) && !pending_q;
  assign xfer      = cmd_valid && cmd_ready;
  assign trip      = fault && (state_q != S_FAULT);
  assign nt        = pending_q ? sh_q : tgt_q;

  always_comb begin
    ramped = '0;
    for (int i = 0; i < 3; i++) ramped[i] = ramp_step(d_q[i], nt[i]);
  end
  assign ramp_done = (ramped == nt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      d_q             <= '0;
      sh_q            <= '0;
      tgt_q           <= '0;
      pending_q       <= 1'b0;
      gate_en_q       <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      d_q             <= d_d;
      sh_q            <= sh_d;
      tgt_q           <= tgt_d;
      pending_q       <= pending_d;
      gate_en_q       <= gate_en_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fault) state_d = S_FAULT;
               else if (period_tick && enable) state_d = S_RAMP;
      S_RAMP:  if (fault) state_d = S_FAULT;
               else if (period_tick) begin
                 if (!enable) state_d = S_IDLE;
                 else if (ramp_done) state_d = S_RUN;
               end
      S_RUN:   if (fault) state_d = S_FAULT;
               else if (period_tick && !enable) state_d = S_IDLE;
      S_FAULT: if (!fault && !enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    d_d             = d_q;
    gate_en_d       = gate_en_q;
    fault_latched_d = fault_latched_q;
    if (trip) begin
      d_d             = '0;
      gate_en_d       = 1'b0;
      fault_latched_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:  if (period_tick && enable) gate_en_d = 1'b1;
        S_RAMP:  if (period_tick) begin
                   if (!enable) begin
                     d_d       = '0;
                     gate_en_d = 1'b0;
                   end else d_d = ramped;
                 end
        S_RUN:   if (period_tick) begin
                   if (!enable) begin
                     d_d       = '0;
                     gate_en_d = 1'b0;
                   end else d_d = nt;
                 end
        S_FAULT: if (!fault && !enable) fault_latched_d = 1'b0;
        default: ;
      endcase
    end
  end

  // A command accepted on a tick edge stays pending for the following tick.
  always_comb begin
    sh_d      = sh_q;
    tgt_d     = tgt_q;
    pending_d = pending_q;
    if (xfer)
      for (int i = 0; i < 3; i++) sh_d[i] = clamp_duty(duty_in[i]);
    if (trip) begin
      pending_d = 1'b0;
      tgt_d     = '0;
    end else if (period_tick && (state_q != S_FAULT)) begin
      tgt_d     = nt;
      pending_d = xfer;
    end else if (xfer) begin
      pending_d = 1'b1;
    end
  end

  assign d_a           = d_q[0];
  assign d_b           = d_q[1];
  assign d_c           = d_q[2];
  assign gate_en       = gate_en_q;
  assign state         = state_q;
  assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_vsi_pwm_scheduler.sv
// Self-checking bench for vsi_pwm_scheduler: expected outputs are queued as stimulus is driven
// and popped for comparison after the edge; clamp cases run from a vector table.
module tb_vsi_pwm_scheduler;

  localparam logic [1:0] S_IDLE = 2'd0, S_RAMP = 2'd1, S_RUN = 2'd2, S_FAULT = 2'd3;

  logic       clk = 1'b0, rst = 1'b0, enable = 1'b0, fault = 1'b0;
  logic       period_tick = 1'b0, cmd_valid = 1'b0;
  logic [9:0] duty_a = '0, duty_b = '0, duty_c = '0;
  logic       cmd_ready, gate_en, fault_latched;
  logic [9:0] d_a, d_b, d_c;
  logic [1:0] state;

  vsi_pwm_scheduler #(.DW(10), .DUTY_MAX(1000), .RAMP_STEP(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fault(fault), .period_tick(period_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
    .d_a(d_a), .d_b(d_b), .d_c(d_c), .gate_en(gate_en), .state(state),
    .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [9:0] a, b, c;
    logic       ge;
    logic [1:0] st;
    logic       fl;
  } exp_t;

  typedef struct {
    int ia, ib, ic;
    int ea, eb, ec;
  } vec_t;

  exp_t sb_q[$];
  vec_t vt[4];
  int   n_total = 0;
  int   n_pass  = 0;
  int   pa, pb, pc;

  task automatic expect_out(string nm, int a, int b, int c, logic ge, logic [1:0] st, logic fl);
    exp_t e;
    e.name = nm; e.a = 10'(a); e.b = 10'(b); e.c = 10'(c);
    e.ge = ge; e.st = st; e.fl = fl;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: no expected record queued");
      return;
    end
    e = sb_q.pop_front();
    if (d_a === e.a && d_b === e.b && d_c === e.c && gate_en === e.ge &&
        state === e.st && fault_latched === e.fl)
      n_pass++;
    else
      $display("FAIL %s: got d=%0d/%0d/%0d gate_en=%b state=%0d fault_latched=%b, want d=%0d/%0d/%0d gate_en=%b state=%0d fault_latched=%b (t=%0t)",
               e.name, d_a, d_b, d_c, gate_en, state, fault_latched,
               e.a, e.b, e.c, e.ge, e.st, e.fl, $time);
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(int n);
    repeat (n) cyc();
  endtask

  task automatic now_chk(string nm, int a, int b, int c, logic ge, logic [1:0] st, logic fl);
    expect_out(nm, a, b, c, ge, st, fl);
    compare_out();
  endtask

  task automatic tick_chk(string nm, int a, int b, int c, logic ge, logic [1:0] st, logic fl);
    expect_out(nm, a, b, c, ge, st, fl);
    period_tick = 1'b1;
    cyc();
    period_tick = 1'b0;
    compare_out();
  endtask

  // Tick held for two clocks: each high cycle counts as its own tick.
  task automatic dtick_chk(string nm, int a, int b, int c, logic ge, logic [1:0] st, logic fl);
    expect_out(nm, a, b, c, ge, st, fl);
    period_tick = 1'b1;
    cyc();
    cyc();
    period_tick = 1'b0;
    compare_out();
  endtask

  task automatic send(int a, int b, int c);
    duty_a = 10'(a); duty_b = 10'(b); duty_c = 10'(c);
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) cyc();
    chk1("send_ready", cmd_ready, 1'b1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{ia: 1023, ib: 0,    ic: 500, ea: 1000, eb: 0,    ec: 500};
    vt[1] = '{ia: 1000, ib: 1001, ic: 999, ea: 1000, eb: 1000, ec: 999};
    vt[2] = '{ia: 0,    ib: 1023, ic: 1,   ea: 0,    eb: 1000, ec: 1};
    vt[3] = '{ia: 400,  ib: 400,  ic: 400, ea: 400,  eb: 400,  ec: 400};

    // Reset
    #1 rst = 1'b1;
    #1;
    now_chk("reset", 0, 0, 0, 1'b0, S_IDLE, 1'b0);
    chk1("reset_cmd_ready", cmd_ready, 1'b0);
    gap(2);
    rst = 1'b0;
    #1;
    chk1("post_reset_ready", cmd_ready, 1'b1);

    // Startup and soft start
    send(400, 400, 400);
    chk1("pending_stalls", cmd_ready, 1'b0);
    enable = 1'b1;
    gap(1);
    tick_chk("start_tick", 0, 0, 0, 1'b1, S_RAMP, 1'b0);
    chk1("pending_cleared", cmd_ready, 1'b1);
    for (int k = 1; k <= 100; k++) begin
      int v;
      v = (4 * k > 400) ? 400 : 4 * k;
      gap(2);
      tick_chk("ramp", v, v, v, 1'b1, (k == 100) ? S_RUN : S_RAMP, 1'b0);
    end
    pa = 400; pb = 400; pc = 400;
    gap(3);
    now_chk("run_hold", pa, pb, pc, 1'b1, S_RUN, 1'b0);

    // Clamp and latency
    for (int i = 0; i < 4; i++) begin
      gap(1);
      tick_chk("clamp_pre_tick", pa, pb, pc, 1'b1, S_RUN, 1'b0);
      send(vt[i].ia, vt[i].ib, vt[i].ic);
      chk1("clamp_ready_low", cmd_ready, 1'b0);
      now_chk("clamp_hold", pa, pb, pc, 1'b1, S_RUN, 1'b0);
      gap(3);
      now_chk("clamp_hold_late", pa, pb, pc, 1'b1, S_RUN, 1'b0);
      tick_chk("clamp_apply", vt[i].ea, vt[i].eb, vt[i].ec, 1'b1, S_RUN, 1'b0);
      pa = vt[i].ea; pb = vt[i].eb; pc = vt[i].ec;
    end

    // Command collides with tick
    gap(2);
    duty_a = 10'd200; duty_b = 10'd300; duty_c = 10'd100;
    cmd_valid = 1'b1;
    period_tick = 1'b1;
    expect_out("collision_tick", pa, pb, pc, 1'b1, S_RUN, 1'b0);
    cyc();
    cmd_valid = 1'b0;
    period_tick = 1'b0;
    compare_out();
    chk1("collision_pending", cmd_ready, 1'b0);
    gap(2);
    tick_chk("collision_apply", 200, 300, 100, 1'b1, S_RUN, 1'b0);

    // Disable waits for the tick
    enable = 1'b0;
    gap(3);
    now_chk("disable_before_tick", 200, 300, 100, 1'b1, S_RUN, 1'b0);
    gap(1);
    tick_chk("disable_tick", 0, 0, 0, 1'b0, S_IDLE, 1'b0);
    chk1("idle_ready", cmd_ready, 1'b1);

    // Fault mid-ramp, using double-width ticks to reach 120
    send(500, 500, 500);
    enable = 1'b1;
    gap(1);
    tick_chk("f_start", 0, 0, 0, 1'b1, S_RAMP, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      gap(2);
      dtick_chk("ramp_double_tick", 8 * k, 8 * k, 8 * k, 1'b1, S_RAMP, 1'b0);
    end
    gap(1);
    fault = 1'b1;
    expect_out("fault_trip", 0, 0, 0, 1'b0, S_FAULT, 1'b1);
    cyc();
    fault = 1'b0;
    compare_out();
    chk1("fault_ready_low", cmd_ready, 1'b0);
    gap(2);
    tick_chk("fault_hold_tick", 0, 0, 0, 1'b0, S_FAULT, 1'b1);
    gap(2);
    now_chk("fault_hold_enable", 0, 0, 0, 1'b0, S_FAULT, 1'b1);
    enable = 1'b0;
    expect_out("fault_exit", 0, 0, 0, 1'b0, S_IDLE, 1'b0);
    cyc();
    compare_out();
    // Targets were zeroed by the fault: restart reaches RUN at 0 after one ramp tick
    enable = 1'b1;
    gap(1);
    tick_chk("restart_tick", 0, 0, 0, 1'b1, S_RAMP, 1'b0);
    gap(2);
    tick_chk("restart_zero_target", 0, 0, 0, 1'b1, S_RUN, 1'b0);

    // Asynchronous reset mid-period
    send(300, 200, 100);
    gap(1);
    tick_chk("pre_reset_run", 300, 200, 100, 1'b1, S_RUN, 1'b0);
    gap(1);
    #2 rst = 1'b1;
    #1;
    now_chk("async_reset", 0, 0, 0, 1'b0, S_IDLE, 1'b0);
    chk1("async_reset_ready", cmd_ready, 1'b0);
    cyc();
    rst = 1'b0;
    enable = 1'b0;
    #1;
    chk1("release_ready", cmd_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
